// File: rtl/fadd_arb.sv
// rtl/fadd_arb.sv - two-requester arbiter sharing one fadd; FADD_ARB_SUB_EN enables rN_sub subtraction
module fadd (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] res
);
  logic        x_nan, y_nan, x_inf, y_inf;
  logic [30:0] x_mag, y_mag, a_mag, b_mag;
  logic        a_s, b_s, swap, up;
  logic [7:0]  a_e, b_e, d;
  logic [23:0] a_m, b_m;
  logic [26:0] b_ext, b_al, norm;
  logic [27:0] sum;
  logic [4:0]  msb;
  logic [9:0]  exp_u, exp_r;
  logic [24:0] mant_r;

  // Single-precision add: flush denormals, align, add/sub, normalise, round to nearest even
  always_comb begin
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_mag = (x[30:23] == 8'h00) ? 31'd0 : x[30:0];
    y_mag = (y[30:23] == 8'h00) ? 31'd0 : y[30:0];
    swap  = y_mag > x_mag;
    a_mag = swap ? y_mag : x_mag;
    b_mag = swap ? x_mag : y_mag;
    a_s   = swap ? y[31] : x[31];
    b_s   = swap ? x[31] : y[31];
    a_e   = a_mag[30:23];
    b_e   = b_mag[30:23];
    a_m   = (a_e == 8'd0) ? 24'd0 : {1'b1, a_mag[22:0]};
    b_m   = (b_e == 8'd0) ? 24'd0 : {1'b1, b_mag[22:0]};
    d     = a_e - b_e;
    b_ext = {b_m, 3'b000};
    // Bits shifted out of the smaller operand collapse into a sticky bit at position 0
    if (d >= 8'd27) begin
      b_al = {26'd0, |b_m};
    end else begin
      b_al = (b_ext >> d) | {26'd0, |(b_ext & ~(27'h7FF_FFFF << d))};
    end
    sum = (a_s == b_s) ? ({1'b0, a_m, 3'b000} + {1'b0, b_al})
                       : ({1'b0, a_m, 3'b000} - {1'b0, b_al});
    msb = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (sum[i]) msb = i[4:0];
    end
    norm   = sum[27] ? (sum[27:1] | {26'd0, sum[0]}) : (sum[26:0] << (5'd26 - msb));
    exp_u  = {2'b00, a_e} + {5'd0, msb} - 10'd26;
    up     = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, up};
    exp_r  = exp_u + {9'd0, mant_r[24]};
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
      res = 32'h7FC0_0000;
    end else if (x_inf) begin
      res = {x[31], 8'hFF, 23'd0};
    end else if (y_inf) begin
      res = {y[31], 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      res = {a_s & b_s, 31'd0};
    end else if (exp_u[9] || (exp_r == 10'd0)) begin
      res = {a_s, 31'd0};
    end else if (exp_r >= 10'd255) begin
      res = {a_s, 8'hFF, 23'd0};
    end else begin
      res = {a_s, exp_r[7:0], mant_r[22:0]};
    end
  end
endmodule

module fadd_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_x,
  input  logic [31:0]      r0_y,
  input  logic             r0_sub,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_x,
  input  logic [31:0]      r1_y,
  input  logic             r1_sub,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_res,
  output logic             o_id,
  output logic [TAG_W-1:0] o_tag
);
  logic             s1_valid, s2_valid, ptr;
  logic [31:0]      s1_x, s1_y, s2_res, add_res, sel_y;
  logic             s1_id, s2_id;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             s2_adv, can_acc, gnt, acc;

  assign s2_adv   = !s2_valid || o_ready;
  assign can_acc  = !s1_valid || s2_adv;
  assign gnt      = (r0_valid && r1_valid) ? !ptr : r1_valid;
  assign r0_ready = rstn && can_acc && r0_valid && !gnt;
  assign r1_ready = rstn && can_acc && r1_valid && gnt;
  assign acc      = (r0_valid && r0_ready) || (r1_valid && r1_ready);

`ifdef FADD_ARB_SUB_EN
  assign sel_y = gnt ? {r1_y[31] ^ r1_sub, r1_y[30:0]} : {r0_y[31] ^ r0_sub, r0_y[30:0]};
`else
  logic unused_sub;
  assign unused_sub = r0_sub ^ r1_sub;
  assign sel_y      = gnt ? r1_y : r0_y;
`endif

  fadd u_fadd (
    .x  (s1_x),
    .y  (s1_y),
    .res(add_res)
  );

  // Pipeline registers and last-grant pointer; S2 holds while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_id    <= 1'b0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_id    <= 1'b0;
      s2_tag   <= '0;
      ptr      <= 1'b1;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res <= add_res;
          s2_id  <= s1_id;
          s2_tag <= s1_tag;
        end
      end
      if (acc) begin
        s1_valid <= 1'b1;
        s1_x     <= gnt ? r1_x : r0_x;
        s1_y     <= sel_y;
        s1_id    <= gnt;
        s1_tag   <= gnt ? r1_tag : r0_tag;
        ptr      <= gnt;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign o_valid = s2_valid;
  assign o_res   = s2_res;
  assign o_id    = s2_id;
  assign o_tag   = s2_tag;
endmodule

// File: tb/tb_fadd_arb.sv
// tb/tb_fadd_arb.sv - randomized scoreboard bench for fadd_arb
module tb_fadd_arb;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             r0_valid, r0_ready, r0_sub, r1_valid, r1_ready, r1_sub;
  logic [31:0]      r0_x, r0_y, r1_x, r1_y, o_res;
  logic [TAG_W-1:0] r0_tag, r1_tag, o_tag;
  logic             o_valid, o_ready, o_id;

  always #5 clk = ~clk;

  fadd_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y), .r0_sub(r0_sub), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y), .r1_sub(r1_sub), .r1_tag(r1_tag),
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_id(o_id), .o_tag(o_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e, mi;
    real r;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    mi = {8'd0, 1'b1, b[22:0]};
    r  = $itor(mi) * pow2(e - 150);
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    real  a, scaled, fr;
    int   e, m;
    logic [7:0] eb;
    if (v == 0.0) return 32'd0;
    s = v < 0.0;
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    scaled = a * 8388608.0;
    m      = $rtoi(scaled);
    fr     = scaled - $itor(m);
    if (fr > 0.5 || (fr == 0.5 && m[0])) m++;
    if (m == 16777216) begin m = 8388608; e++; end
    eb = 8'(e + 127);
    return {s, eb, m[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic neg;
    real  yv;
`ifdef FADD_ARB_SUB_EN
    neg = sub;
`else
    neg = 1'b0 & sub;
`endif
    yv = f2r(y);
    if (neg) yv = -yv;
    return r2f(f2r(x) + yv);
  endfunction

  typedef struct {
    logic [31:0]      res;
    logic             id;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t             q[$];
  logic             last_g = 1'b1;
  int               cyc = 0;
  logic             held = 1'b0;
  logic [37:0]      held_v;

  // Reference model: round-robin grant, 2-deep in-flight limit, in-order results 2 edges after accept
  always @(negedge clk) begin : monitor
    logic       g, room;
    logic [1:0] exp_rdy;
    logic       exp_ov;
    exp_t       e;
    cyc++;
    if (!rstn) begin
      check_eq("rst_o_valid", o_valid, 1'b0);
      check_eq("rst_ready", {r1_ready, r0_ready}, 2'b00);
      check_eq("rst_o_word", {o_res, o_id, o_tag}, 38'd0);
      q.delete();
      last_g = 1'b1;
      held   = 1'b0;
    end else begin
      g       = (r0_valid && r1_valid) ? !last_g : r1_valid;
      room    = (q.size() < 2) || o_ready;
      exp_rdy = ((r0_valid || r1_valid) && room) ? (g ? 2'b10 : 2'b01) : 2'b00;
      check_eq("ready", {r1_ready, r0_ready}, exp_rdy);
      exp_ov = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      check_eq("o_valid", o_valid, exp_ov);
      if (held) check_eq("hold", {o_valid, o_res, o_id, o_tag}, held_v);
      if (o_valid && exp_ov) begin
        check_eq("o_res", o_res, q[0].res);
        check_eq("o_id", o_id, q[0].id);
        check_eq("o_tag", o_tag, q[0].tag);
        if (o_ready) void'(q.pop_front());
      end
      held   = o_valid && !o_ready;
      held_v = {o_valid, o_res, o_id, o_tag};
      if (r0_valid && r0_ready) begin
        e.res = ref_add(r0_x, r0_y, r0_sub); e.id = 1'b0; e.tag = r0_tag; e.cyc = cyc;
        q.push_back(e);
        last_g = 1'b0;
      end
      if (r1_valid && r1_ready) begin
        e.res = ref_add(r1_x, r1_y, r1_sub); e.id = 1'b1; e.tag = r1_tag; e.cyc = cyc;
        q.push_back(e);
        last_g = 1'b1;
      end
    end
  end

  task automatic rand_op(output logic [31:0] x, output logic [31:0] y, output logic sub,
                         output logic [TAG_W-1:0] tag);
    int ex, ey;
    ex = int'($urandom_range(110, 140));
    ey = ex + int'($urandom_range(0, 24)) - 12;
    x  = {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
    if ($urandom_range(0, 7) == 0) y = {1'($urandom_range(0, 1)), x[30:0]};
    else y = {1'($urandom_range(0, 1)), 8'(ey), 23'($urandom)};
    sub = 1'($urandom_range(0, 1));
    tag = TAG_W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int   acc;
    logic hs0, hs1;
    rstn = 1'b0; o_ready = 1'b1;
    r0_valid = 1'b0; r0_x = '0; r0_y = '0; r0_sub = 1'b0; r0_tag = '0;
    r1_valid = 1'b0; r1_x = '0; r1_y = '0; r1_sub = 1'b0; r1_tag = '0;
    repeat (3) tick();

    // Release reset with an op already offered: accepted on the first edge
    rstn = 1'b1;
    r0_valid = 1'b1; r0_x = 32'h3F80_0000; r0_y = 32'h4000_0000; r0_sub = 1'b0; r0_tag = 4'd3;
    tick();
    r0_valid = 1'b0;
    check_eq("lat_edge1_o_valid", o_valid, 1'b0);
    tick();
    check_eq("lat_edge2_o_valid", o_valid, 1'b1);
    check_eq("add_res", o_res, 32'h4040_0000);
    check_eq("add_id", o_id, 1'b0);
    check_eq("add_tag", o_tag, 4'd3);
    tick();

    r1_valid = 1'b1; r1_x = 32'h3FC0_0000; r1_y = 32'h3FC0_0000; r1_sub = 1'b1; r1_tag = 4'd5;
    tick();
    r1_valid = 1'b0;
    tick();
`ifdef FADD_ARB_SUB_EN
    check_eq("sub_res", o_res, 32'h0000_0000);
`else
    check_eq("sub_res", o_res, 32'h4040_0000);
`endif
    check_eq("sub_id", o_id, 1'b1);
    tick();

    // Both requesters held valid: strict alternation starting with r0
    rand_op(r0_x, r0_y, r0_sub, r0_tag);
    rand_op(r1_x, r1_y, r1_sub, r1_tag);
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) check_eq("rr_grant", {r1_ready, r0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 2) check_eq("rr_o_id", {o_valid, o_id}, {1'b1, 1'((i - 2) % 2)});
      tick();
      if (i == 5) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end

    // Consumer stall: two accepts fill the pipe, then no ready
    o_ready = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc += int'(r0_valid && r0_ready) + int'(r1_valid && r1_ready);
      if (i == 3) check_eq("stall_ready", {r1_ready, r0_ready}, 2'b00);
      tick();
    end
    check_eq("stall_accepts", acc, 2);
    r0_valid = 1'b0; r1_valid = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    check_eq("stall_drain", q.size(), 0);
    tick();

    // Reset with two ops in flight
    o_ready = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    #1;
    check_eq("async_rst_o_valid", o_valid, 1'b0);
    tick(); tick();
    rstn = 1'b1; o_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_grant", {r1_ready, r0_ready}, 2'b01);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (4) tick();

    // Random traffic with random consumer backpressure
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      hs0 = r0_valid && r0_ready;
      hs1 = r1_valid && r1_ready;
      tick();
      if (hs0 || !r0_valid) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        rand_op(r0_x, r0_y, r0_sub, r0_tag);
      end
      if (hs1 || !r1_valid) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        rand_op(r1_x, r1_y, r1_sub, r1_tag);
      end
      o_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0; o_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check_eq("final_drain", q.size(), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fadd_arb.md
FADD_ARB -- requirements
Module: fadd_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the requester-supplied transaction tag.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports r0_valid / r1_valid  input  1 each  requester N offers an operation.
REQ-005 SHALL have ports r0_ready / r1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 SHALL have ports r0_x, r0_y, r1_x, r1_y  input  32 each  IEEE-754 single operands.
REQ-007 SHALL have ports r0_sub / r1_sub  input  1 each  1 = x-y, 0 = x+y.
REQ-008 SHALL have ports r0_tag / r1_tag  input  TAG_W each  opaque tag, returned unchanged.
REQ-009 SHALL have port o_valid  output  1  result available.
REQ-010 SHALL have port o_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port o_res  output  32  result word.
REQ-012 SHALL have port o_id  output  1  index of the requester that issued the result.
REQ-013 SHALL have port o_tag  output  TAG_W  tag of the issuing operation.

Function
REQ-014 SHALL instantiate one combinational fadd unit (x, y -> res) and share it between both requesters.
REQ-015 SHALL be a 2-stage pipeline: S1 holds x, y', id, tag; fadd evaluates from S1; S2 holds res, id, tag. o_* are driven from S2.
REQ-016 SHALL form y' as y with bit 31 inverted when sub=1 and FADD_ARB_SUB_EN is defined; otherwise y' = y.
REQ-017 SHALL have a latency of exactly 2 cycles from the accepting edge to o_valid=1 when o_ready stays 1.
REQ-018 SHALL sustain one accept per cycle while o_ready=1.
REQ-019 SHALL advance S2 when !s2_valid or o_ready; S1 to S2 when S2 advances; accept a new op when !s1_valid or S1 advances.
REQ-020 SHALL compute the grant from r*_valid and a last-grant pointer only, never from o_ready. Only one valid: that requester. Both valid: the one not equal to the pointer.
REQ-021 SHALL assert rN_ready only for the granted requester and only when an accept is possible; at most one ready per cycle.
REQ-022 SHALL update the pointer to the granted index only on a completed handshake (valid and ready).
REQ-023 SHALL hold o_valid, o_res, o_id and o_tag stable while o_valid=1 and o_ready=0.
REQ-024 SHALL hold at most 2 in-flight ops: with S1 and S2 full and o_ready=0, both rN_ready=0.
REQ-025 SHALL, on a simultaneous output pop and new accept, shift S1 to S2 and load S1 in the same edge without bubble or loss.
REQ-026 SHALL pass fadd results unmodified (rounding, underflow flush and overflow are those of fadd).

Reset
REQ-027 SHALL, while rstn=0 and asynchronously, clear s1_valid, s2_valid and the pointer (pointer=1, so r0 wins the first contention).
REQ-028 SHALL drive o_valid=0, r0_ready=0, r1_ready=0, o_res=0, o_id=0 and o_tag=0 during reset.
REQ-029 SHALL discard any in-flight ops when reset is asserted mid-operation; no result for them appears after release.
REQ-030 SHALL allow the first accept on the first rising edge after rstn deasserts.

Configuration
REQ-031 SHALL use macro FADD_ARB_SUB_EN. Defined: rN_sub selects subtraction by negating y. Undefined: rN_sub is ignored and every op is x+y.

Verification
REQ-032 SHALL cover: r0 x=0x3F800000, y=0x40000000, sub=0, tag=3, o_ready=1 -> two edges later o_res=0x40400000, o_id=0, o_tag=3.
REQ-033 SHALL cover: r1 x=y=0x3FC00000, sub=1 -> with FADD_ARB_SUB_EN o_res=0x00000000; without it o_res=0x40400000.
REQ-034 SHALL cover: r0 and r1 held valid for 6 cycles, o_ready=1 -> grants r0,r1,r0,r1,r0,r1 and o_id follows the same order.
REQ-035 SHALL cover: o_ready=0 for 4 cycles with both requesters valid -> 2 accepts then rN_ready=0; o_* stable; after release results drain in order with no loss.
REQ-036 SHALL cover: rstn pulsed low with 2 ops in flight -> o_valid=0 immediately and no stale result afterwards; the next contention grants r0.
